// File: rtl/led_uart_mmio_pkg.sv
// Shared constants and types for the LED/UART/seven-segment MMIO peripheral.
// Holds the bus widths, register map and the UART transmitter state type.
package led_uart_mmio_pkg;

    localparam int XLEN         = 32;
    localparam int ADDR_W       = 32;
    localparam int IO_LED_WIDTH = 16;

    localparam logic [ADDR_W-1:0] IO_BASE_ADDR        = 32'hF000_0000;
    localparam logic [ADDR_W-1:0] IO_LED_OFFSET       = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] IO_UART_TX_OFFSET   = 32'h0000_0004;
    localparam logic [ADDR_W-1:0] IO_UART_STAT_OFFSET = 32'h0000_0008;
    localparam logic [ADDR_W-1:0] IO_SEG_OFFSET       = 32'h0000_000C;
    localparam logic [ADDR_W-1:0] IO_BTN_OFFSET       = 32'h0000_0010;

    localparam int IO_UART_STAT_BUSY_BIT = 0;

    typedef enum logic {
        UART_IDLE,
        UART_SEND
    } uart_state_t;

endpackage

// File: rtl/led_uart_mmio_uart_tx_core.sv
// Transmit-only 8N1 UART: one start bit, eight data bits LSB first, one stop bit.
// Each bit lasts DIV clock cycles; start requests are ignored while busy.
module uart_tx_core
    import led_uart_mmio_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    uart_state_t state, state_next;
    logic [DW-1:0] div_cnt, div_next;
    logic [3:0]    bit_cnt, bit_next;
    logic [9:0]    frame, frame_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= UART_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            frame   <= '1;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
            bit_cnt <= bit_next;
            frame   <= frame_next;
            tx      <= (state_next == UART_SEND) ? frame_next[0] : 1'b1;
        end
    end

    // Frame is shifted out of bit 0, refilling with stop-level ones.
    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        frame_next = frame;
        case (state)
            UART_IDLE: begin
                if (start) begin
                    state_next = UART_SEND;
                    frame_next = {1'b1, data, 1'b0};
                    div_next   = '0;
                    bit_next   = '0;
                end
            end
            UART_SEND: begin
                if (div_cnt == DIV_LAST) begin
                    div_next   = '0;
                    frame_next = {1'b1, frame[9:1]};
                    if (bit_cnt == 4'd9) begin
                        state_next = UART_IDLE;
                    end else begin
                        bit_next = bit_cnt + 4'd1;
                    end
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            default: state_next = UART_IDLE;
        endcase
    end

    assign busy = (state == UART_SEND);

endmodule

// File: rtl/led_uart_mmio.sv
// MMIO peripheral: LED register, 8N1 UART transmitter, button input and an
// optional 8-digit hex seven-segment driver enabled by LED_UART_MMIO_SEG_EN.
module led_uart_mmio
    import led_uart_mmio_pkg::*;
#(
    parameter int UART_DIV = 868,
    parameter int SCAN_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mmio_req,
    input  logic                    mmio_we,
    input  logic [ADDR_W-1:0]       mmio_addr,
    input  logic [XLEN-1:0]         mmio_wdata,
    output logic [XLEN-1:0]         mmio_rdata,
    output logic                    mmio_ready,
    output logic [IO_LED_WIDTH-1:0] led_out,
    output logic [7:0]              seg0,
    output logic [7:0]              seg1,
    output logic [7:0]              seg_an,
    input  logic [4:0]              btn_in,
    output logic                    uart_tx
);

    logic accept;
    logic sel_led, sel_tx, sel_stat, sel_seg, sel_btn;
    logic uart_busy;
    logic [4:0] btn_meta, btn_sync;
    logic [XLEN-1:0] seg_rd;
    logic [XLEN-1:0] rd_val;

    // A request is taken only when no completion is pending, so a held
    // request produces a new access every other cycle.
    assign accept   = mmio_req && !mmio_ready;
    assign sel_led  = (mmio_addr == IO_BASE_ADDR + IO_LED_OFFSET);
    assign sel_tx   = (mmio_addr == IO_BASE_ADDR + IO_UART_TX_OFFSET);
    assign sel_stat = (mmio_addr == IO_BASE_ADDR + IO_UART_STAT_OFFSET);
    assign sel_seg  = (mmio_addr == IO_BASE_ADDR + IO_SEG_OFFSET);
    assign sel_btn  = (mmio_addr == IO_BASE_ADDR + IO_BTN_OFFSET);

    always_comb begin
        rd_val = '0;
        if (sel_led)  rd_val = {{(XLEN-IO_LED_WIDTH){1'b0}}, led_out};
        if (sel_stat) rd_val[IO_UART_STAT_BUSY_BIT] = uart_busy;
        if (sel_seg)  rd_val = seg_rd;
        if (sel_btn)  rd_val = {{(XLEN-5){1'b0}}, btn_sync};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmio_ready <= 1'b0;
            mmio_rdata <= '0;
            led_out    <= '0;
        end else begin
            mmio_ready <= accept;
            if (accept && !mmio_we) mmio_rdata <= rd_val;
            if (accept && mmio_we && sel_led) led_out <= mmio_wdata[IO_LED_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= btn_in;
            btn_sync <= btn_meta;
        end
    end

    uart_tx_core #(.DIV(UART_DIV)) u_uart_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && mmio_we && sel_tx),
        .data  (mmio_wdata[7:0]),
        .tx    (uart_tx),
        .busy  (uart_busy)
    );

`ifdef LED_UART_MMIO_SEG_EN
    localparam int SCAN_W = $clog2(SCAN_DIV + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [XLEN-1:0]   seg_reg;
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        digit_idx;
    logic [7:0]        digit_font;

    // Segment order {dp,g,f,e,d,c,b,a}; decimal point always off.
    function automatic logic [7:0] hex_font(input logic [3:0] nib);
        hex_font = 8'h00;
        case (nib)
            4'h0: hex_font = 8'h3F;  4'h1: hex_font = 8'h06;
            4'h2: hex_font = 8'h5B;  4'h3: hex_font = 8'h4F;
            4'h4: hex_font = 8'h66;  4'h5: hex_font = 8'h6D;
            4'h6: hex_font = 8'h7D;  4'h7: hex_font = 8'h07;
            4'h8: hex_font = 8'h7F;  4'h9: hex_font = 8'h6F;
            4'hA: hex_font = 8'h77;  4'hB: hex_font = 8'h7C;
            4'hC: hex_font = 8'h39;  4'hD: hex_font = 8'h5E;
            4'hE: hex_font = 8'h79;  4'hF: hex_font = 8'h71;
            default: hex_font = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            seg_reg   <= '0;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (accept && mmio_we && sel_seg) seg_reg <= mmio_wdata;
        end
    end

    // Digits 0-3 drive the seg0 bank, digits 4-7 the seg1 bank.
    assign digit_font = hex_font(seg_reg[{digit_idx, 2'b00} +: 4]);
    assign seg_an     = 8'h01 << digit_idx;
    assign seg0       = digit_idx[2] ? 8'h00 : digit_font;
    assign seg1       = digit_idx[2] ? digit_font : 8'h00;
    assign seg_rd     = seg_reg;
`else
    logic unused_wdata_hi;

    assign unused_wdata_hi = ^mmio_wdata[XLEN-1:IO_LED_WIDTH];
    assign seg_an = 8'h00;
    assign seg0   = 8'h00;
    assign seg1   = 8'h00;
    assign seg_rd = '0;
`endif

endmodule

// File: tb/tb_led_uart_mmio.sv
// Self-checking bench for led_uart_mmio: table-driven register accesses with a
// read scoreboard, plus hand sequences for handshake, UART framing, buttons and scan.
module tb_led_uart_mmio;
    import led_uart_mmio_pkg::*;

    localparam int UART_DIV = 8;
    localparam int SCAN_DIV = 1;

    localparam logic [31:0] A_LED  = IO_BASE_ADDR + IO_LED_OFFSET;
    localparam logic [31:0] A_TX   = IO_BASE_ADDR + IO_UART_TX_OFFSET;
    localparam logic [31:0] A_STAT = IO_BASE_ADDR + IO_UART_STAT_OFFSET;
    localparam logic [31:0] A_SEG  = IO_BASE_ADDR + IO_SEG_OFFSET;
    localparam logic [31:0] A_BTN  = IO_BASE_ADDR + IO_BTN_OFFSET;
    localparam logic [31:0] A_UNM  = IO_BASE_ADDR + 32'h40;
`ifdef LED_UART_MMIO_SEG_EN
    localparam logic [31:0] SEG_EXP = 32'h7654_3210;
`else
    localparam logic [31:0] SEG_EXP = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mmio_req, mmio_we;
    logic [31:0] mmio_addr, mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        mmio_ready;
    logic [15:0] led_out;
    logic [7:0]  seg0, seg1, seg_an;
    logic [4:0]  btn_in;
    logic        uart_tx;

    led_uart_mmio #(.UART_DIV(UART_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .mmio_req(mmio_req), .mmio_we(mmio_we),
        .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
        .mmio_ready(mmio_ready), .led_out(led_out), .seg0(seg0), .seg1(seg1),
        .seg_an(seg_an), .btn_in(btn_in), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference digit index: steps once per clock when SCAN_DIV is 1.
    logic [2:0] m_idx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_idx <= 3'd0;
        else        m_idx <= m_idx + 3'd1;
    end

    logic [7:0] font_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                  8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_led;
        string       name;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] expv;
    } sb_t;

    vec_t vecs [16];
    sb_t  exp_q [$];
    int   checks = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    // Drives one access from a negedge and returns at the negedge where ready is seen.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expv, input string name);
        sb_t ent;
        bit  got;
        mmio_req   = 1'b1;
        mmio_we    = we;
        mmio_addr  = addr;
        mmio_wdata = wdata;
        if (!we) begin
            ent.name = name;
            ent.expv = expv;
            exp_q.push_back(ent);
        end
        got = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mmio_ready) begin
                got = 1;
                break;
            end
        end
        mmio_req = 1'b0;
        if (!got) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
        if (!we && exp_q.size() > 0) begin
            ent = exp_q.pop_front();
            if (got) checkOutput(ent.name, mmio_rdata, ent.expv);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    int          c0;
    logic [9:0]  frame;
    logic [15:0] rnd;
    logic [7:0]  exp_font;

    initial begin
        rst_n = 1'b0; mmio_req = 1'b0; mmio_we = 1'b0;
        mmio_addr = '0; mmio_wdata = '0; btn_in = '0;

        vecs[0]  = '{1'b1, A_LED,  32'h0000_A5A5, 32'h0,         16'hA5A5, "led_wr"};
        vecs[1]  = '{1'b0, A_LED,  32'h0,         32'h0000_A5A5, 16'hA5A5, "led_rd"};
        vecs[2]  = '{1'b1, A_LED,  32'hFFFF_1234, 32'h0,         16'h1234, "led_wr_hi"};
        vecs[3]  = '{1'b0, A_LED,  32'h0,         32'h0000_1234, 16'h1234, "led_rd_hi0"};
        vecs[4]  = '{1'b0, A_TX,   32'h0,         32'h0,         16'h1234, "tx_rd0"};
        vecs[5]  = '{1'b1, A_STAT, 32'hFFFF_FFFF, 32'h0,         16'h1234, "stat_wr"};
        vecs[6]  = '{1'b0, A_STAT, 32'h0,         32'h0,         16'h1234, "stat_idle"};
        vecs[7]  = '{1'b1, A_UNM,  32'hDEAD_BEEF, 32'h0,         16'h1234, "unm_wr"};
        vecs[8]  = '{1'b0, A_UNM,  32'h0,         32'h0,         16'h1234, "unm_rd"};
        vecs[9]  = '{1'b0, A_LED,  32'h0,         32'h0000_1234, 16'h1234, "led_after_unm"};
        vecs[10] = '{1'b0, A_SEG,  32'h0,         32'h0,         16'h1234, "seg_rd_rst"};
        vecs[11] = '{1'b1, A_SEG,  32'h7654_3210, 32'h0,         16'h1234, "seg_wr"};
        vecs[12] = '{1'b0, A_SEG,  32'h0,         SEG_EXP,       16'h1234, "seg_rd"};
        vecs[13] = '{1'b1, IO_BASE_ADDR + 32'h100, 32'h0000_FFFF, 32'h0, 16'h1234, "alias_wr"};
        vecs[14] = '{1'b0, A_LED,  32'h0,         32'h0000_1234, 16'h1234, "led_after_alias"};
        vecs[15] = '{1'b0, A_BTN,  32'h0,         32'h0,         16'h1234, "btn_idle"};

        repeat (3) @(negedge clk);
        checkOutput("rst_led", {16'h0, led_out}, 32'h0);
        checkOutput("rst_tx", {31'h0, uart_tx}, 32'h1);
        checkOutput("rst_ready", {31'h0, mmio_ready}, 32'h0);
        checkOutput("rst_rdata", mmio_rdata, 32'h0);
`ifdef LED_UART_MMIO_SEG_EN
        checkOutput("rst_seg_an", {24'h0, seg_an}, 32'h01);
        checkOutput("rst_seg0", {24'h0, seg0}, 32'h3F);
`else
        checkOutput("rst_seg_an", {24'h0, seg_an}, 32'h00);
        checkOutput("rst_seg0", {24'h0, seg0}, 32'h00);
`endif
        checkOutput("rst_seg1", {24'h0, seg1}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Held request: ready pulses 1,0,1,0 then stays low once req drops.
        mmio_req = 1'b1; mmio_we = 1'b0; mmio_addr = A_LED;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("ready_held_%0d", i), {31'h0, mmio_ready}, {31'h0, ~i[0]});
        end
        mmio_req = 1'b0;
        @(negedge clk);
        checkOutput("ready_idle", {31'h0, mmio_ready}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].name);
            checkOutput({vecs[i].name, "_led"}, {16'h0, led_out}, {16'h0, vecs[i].exp_led});
        end

        for (int i = 0; i < 20; i++) begin
            rnd = 16'($urandom);
            applyStimulus(1'b1, A_LED, {16'($urandom), rnd}, 32'h0, "rand_wr");
            checkOutput("rand_led", {16'h0, led_out}, {16'h0, rnd});
            applyStimulus(1'b0, A_LED, 32'h0, {16'h0, rnd}, "rand_rd");
        end

        btn_in = 5'b10101;
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, A_BTN, 32'h0, 32'h15, "btn_rd");

        // Busy is visible right after the TX write and clears after ten bit times.
        applyStimulus(1'b1, A_TX, 32'h55, 32'h0, "tx_wr");
        c0 = cyc;
        applyStimulus(1'b0, A_STAT, 32'h0, 32'h1, "stat_busy");
        wait_until(c0 + 10 * UART_DIV + 4);
        checkOutput("tx_idle_after", {31'h0, uart_tx}, 32'h1);
        applyStimulus(1'b0, A_STAT, 32'h0, 32'h0, "stat_done");

        // Mid-bit sampling of a 0x55 frame with an ignored write part way through.
        frame = {1'b1, 8'h55, 1'b0};
        applyStimulus(1'b1, A_TX, 32'h55, 32'h0, "tx_wr2");
        c0 = cyc;
        for (int k = 0; k < 10; k++) begin
            wait_until(c0 + UART_DIV * k + UART_DIV / 2);
            checkOutput($sformatf("tx_bit_%0d", k), {31'h0, uart_tx}, {31'h0, frame[k]});
            if (k == 2) applyStimulus(1'b1, A_TX, 32'hFF, 32'h0, "tx_wr_busy");
        end
        wait_until(c0 + 10 * UART_DIV + 4);
        checkOutput("tx_idle_after2", {31'h0, uart_tx}, 32'h1);
        applyStimulus(1'b0, A_STAT, 32'h0, 32'h0, "stat_done2");

        applyStimulus(1'b1, A_SEG, 32'h7654_3210, 32'h0, "seg_wr2");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
`ifdef LED_UART_MMIO_SEG_EN
            exp_font = font_tbl[{1'b0, m_idx}];
            checkOutput("seg_an_scan", {24'h0, seg_an}, {24'h0, 8'h01 << m_idx});
            checkOutput("seg0_scan", {24'h0, seg0}, {24'h0, m_idx[2] ? 8'h00 : exp_font});
            checkOutput("seg1_scan", {24'h0, seg1}, {24'h0, m_idx[2] ? exp_font : 8'h00});
`else
            checkOutput("seg_an_off", {24'h0, seg_an}, 32'h0);
            checkOutput("seg0_off", {24'h0, seg0}, 32'h0);
            checkOutput("seg1_off", {24'h0, seg1}, 32'h0);
`endif
        end

        // Reset in the middle of an all-zero frame must release the line at once.
        applyStimulus(1'b1, A_TX, 32'h00, 32'h0, "tx_wr_abort");
        c0 = cyc;
        wait_until(c0 + 20);
        checkOutput("tx_low_mid", {31'h0, uart_tx}, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("tx_abort_high", {31'h0, uart_tx}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, A_STAT, 32'h0, 32'h0, "stat_after_abort");
        applyStimulus(1'b0, A_LED, 32'h0, 32'h0, "led_after_rst");
        repeat (UART_DIV) @(negedge clk);
        checkOutput("tx_stays_high", {31'h0, uart_tx}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
